// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared types and defaults for the fetch/data memory arbiter
//
// Contents:
//   arb_state_t        arbiter state encoding (IDLE, GNT_IF, GNT_DM)
//   MAX_BURST_DEFAULT  default limit on consecutive data grants while fetch waits
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    GNT_IF = 2'b01,
    GNT_DM = 2'b10
  } arb_state_t;

  localparam int MAX_BURST_DEFAULT = 4;

endpackage

// File: rtl/mem_arbiter_burst_counter.sv
// rtl/mem_arbiter_burst_counter.sv - saturating count of data grants taken while fetch waits
//
// Ports:
//   clk      in   clock
//   reset_n  in   asynchronous active-low reset
//   inc      in   data grant issued while fetch is requesting
//   clr      in   fetch granted, or fetch not requesting in an idle cycle
//   cnt      out  current count, saturates at MAX_BURST
module arb_burst_counter
  import mem_arbiter_pkg::*;
#(
  parameter int MAX_BURST = MAX_BURST_DEFAULT,
  parameter int CNT_W     = 3
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != CNT_MAX)) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - single-port memory arbiter between instruction fetch and data stage
//
// Ports:
//   clk, reset_n                       clock, asynchronous active-low reset
//   if_req, if_addr                    fetch read request / address
//   if_ack, if_rdata                   fetch completion pulse / read data
//   dm_req, dm_rw, dm_size             data request, 1=store 0=load, 1=byte 0=word
//   dm_addr, dm_wdata                  data address / store data
//   dm_ack, dm_rdata                   data completion pulse / load data
//   mem_en, mem_rw, mem_size           memory strobe, direction, size
//   mem_addr, mem_wdata                memory address / write data
//   mem_rdata, mem_ready               memory read data / completion
//   stall_if, stall_mem                pipeline stalls for fetch / memory stage
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int MAX_BURST = MAX_BURST_DEFAULT
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_ack,
  output logic [31:0] if_rdata,
  input  logic        dm_req,
  input  logic        dm_rw,
  input  logic        dm_size,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  output logic        dm_ack,
  output logic [31:0] dm_rdata,
  output logic        mem_en,
  output logic        mem_rw,
  output logic        mem_size,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic        stall_if,
  output logic        stall_mem
);

  localparam int CNT_W = (MAX_BURST < 1) ? 1 : $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST);

  arb_state_t       state;
  logic             mem_en_q;
  logic [31:0]      addr_q;
  logic [31:0]      wdata_q;
  logic             rw_q;
  logic             size_q;
  logic [CNT_W-1:0] burst_cnt;

  logic in_idle;
  logic dm_wins;
  logic grant_dm;
  logic grant_if;

  // Data normally wins (its instruction is older), unless it has already
  // taken MAX_BURST grants in a row while fetch was waiting.
  assign in_idle  = (state == IDLE);
  assign dm_wins  = dm_req && ((burst_cnt < CNT_MAX) || !if_req);
  assign grant_dm = in_idle && dm_wins;
  assign grant_if = in_idle && !dm_wins && if_req;

  arb_burst_counter #(
    .MAX_BURST (MAX_BURST),
    .CNT_W     (CNT_W)
  ) u_burst (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (grant_dm && if_req),
    .clr     (grant_if || (in_idle && !if_req)),
    .cnt     (burst_cnt)
  );

  // Grant states always return to IDLE, so a request can never be
  // regranted in its own ack cycle. A requester dropping its request
  // mid-grant does not abort the access: only mem_ready ends it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      mem_en_q <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rw_q     <= 1'b0;
      size_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_dm) begin
            state    <= GNT_DM;
            mem_en_q <= 1'b1;
            addr_q   <= dm_addr;
            wdata_q  <= dm_wdata;
            rw_q     <= dm_rw;
            size_q   <= dm_size;
          end else if (grant_if) begin
            state    <= GNT_IF;
            mem_en_q <= 1'b1;
            addr_q   <= if_addr;
            wdata_q  <= '0;
            rw_q     <= 1'b0;
            size_q   <= 1'b0;
          end
        end
        GNT_IF, GNT_DM: begin
          if (mem_ready) begin
            state    <= IDLE;
            mem_en_q <= 1'b0;
          end
        end
        default: begin
          state    <= IDLE;
          mem_en_q <= 1'b0;
        end
      endcase
    end
  end

  assign mem_en    = mem_en_q;
  assign mem_rw    = rw_q;
  assign mem_size  = size_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

  // Acks complete in the same cycle mem_ready arrives; mem_ready seen in
  // IDLE is ignored because no grant state is active.
  assign if_ack   = (state == GNT_IF) && mem_ready;
  assign dm_ack   = (state == GNT_DM) && mem_ready;
  assign if_rdata = if_ack ? mem_rdata : '0;
  assign dm_rdata = dm_ack ? mem_rdata : '0;

  assign stall_if  = reset_n && if_req && !if_ack;
  assign stall_mem = reset_n && dm_req && !dm_ack;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - scoreboard bench for mem_arbiter
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        if_req, dm_req, dm_rw, dm_size;
  logic [31:0] if_addr, dm_addr, dm_wdata;
  logic        if_ack, dm_ack;
  logic [31:0] if_rdata, dm_rdata;
  logic        mem_en, mem_rw, mem_size;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic        stall_if, stall_mem;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int total_acks = 0;
  int if_ack_cyc = 0;
  int dm_ack_cyc = 0;
  int wait_cfg = 0;
  int wcnt = 0;
  bit idle_ready = 1'b0;

  typedef struct {
    bit          is_dm;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        rw;
    logic        size;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  mem_arbiter #(.MAX_BURST(4)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_ack    (if_ack),
    .if_rdata  (if_rdata),
    .dm_req    (dm_req),
    .dm_rw     (dm_rw),
    .dm_size   (dm_size),
    .dm_addr   (dm_addr),
    .dm_wdata  (dm_wdata),
    .dm_ack    (dm_ack),
    .dm_rdata  (dm_rdata),
    .mem_en    (mem_en),
    .mem_rw    (mem_rw),
    .mem_size  (mem_size),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready),
    .stall_if  (stall_if),
    .stall_mem (stall_mem)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return (a * 32'd3) ^ 32'hC0DE_0F00;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_exp(input bit is_dm, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic rw, input logic size);
    exp_t e;
    e.is_dm = is_dm;
    e.addr  = addr;
    e.wdata = wdata;
    e.rw    = rw;
    e.size  = size;
    exp_q.push_back(e);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Memory model: mem_ready after wait_cfg wait cycles of an active strobe.
  initial begin
    mem_ready = 1'b0;
    mem_rdata = 32'h0;
    forever begin
      @(posedge clk);
      #1;
      if (mem_en) begin
        mem_ready = (wcnt >= wait_cfg);
        wcnt++;
        mem_rdata = mem_fn(mem_addr);
      end else begin
        mem_ready = idle_ready;
        wcnt = 0;
        mem_rdata = 32'hDEAD_BEEF;
      end
    end
  end

  // Monitor: pops the scoreboard whenever the DUT acks.
  always @(negedge clk) begin
    if (reset_n) begin
      if (if_ack || dm_ack) begin
        total_acks++;
        if (if_ack) if_ack_cyc = cyc;
        if (dm_ack) dm_ack_cyc = cyc;
        if (exp_q.size() == 0) begin
          chk("unexpected_ack", {30'h0, if_ack, dm_ack}, 32'h0);
        end else begin
          mon_e = exp_q.pop_front();
          chk("ack_if", {31'h0, if_ack}, {31'h0, !mon_e.is_dm});
          chk("ack_dm", {31'h0, dm_ack}, {31'h0, mon_e.is_dm});
          chk("ack_rdata", mon_e.is_dm ? dm_rdata : if_rdata, mem_fn(mon_e.addr));
          chk("mem_en_at_ack", {31'h0, mem_en}, 32'h1);
          chk("mem_addr", mem_addr, mon_e.addr);
          chk("mem_wdata", mem_wdata, mon_e.wdata);
          chk("mem_rw", {31'h0, mem_rw}, {31'h0, mon_e.rw});
          chk("mem_size", {31'h0, mem_size}, {31'h0, mon_e.size});
        end
      end
      if (!if_ack) chk("if_rdata_zero", if_rdata, 32'h0);
      if (!dm_ack) chk("dm_rdata_zero", dm_rdata, 32'h0);
    end
  end

  // Requester model: drops each request the cycle after its ack. Data keeps
  // requesting until dm_keep data acks have followed the fetch ack.
  task automatic serve(input int budget, input int dm_keep);
    bit ia, da, if_done;
    int dm_after_if;
    if_done = 1'b0;
    dm_after_if = 0;
    for (int c = 0; c < budget && (if_req || dm_req); c++) begin
      @(negedge clk);
      ia = if_ack;
      da = dm_ack;
      @(posedge clk);
      #1;
      if (ia) begin
        if_req = 1'b0;
        if_done = 1'b1;
      end
      if (da) begin
        if (if_done) dm_after_if++;
        if (dm_keep == 0 || dm_after_if >= dm_keep) dm_req = 1'b0;
      end
    end
    chk("serve_timeout", {30'h0, if_req, dm_req}, 32'h0);
    if_req = 1'b0;
    dm_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  int acks_before;

  initial begin
    reset_n  = 1'b0;
    if_req   = 1'b1;
    dm_req   = 1'b1;
    dm_rw    = 1'b0;
    dm_size  = 1'b0;
    if_addr  = 32'h0;
    dm_addr  = 32'h0;
    dm_wdata = 32'h0;

    // Reset: every output is 0 even with both requests high.
    repeat (2) @(negedge clk);
    chk("rst_mem_en", {31'h0, mem_en}, 32'h0);
    chk("rst_acks", {30'h0, if_ack, dm_ack}, 32'h0);
    chk("rst_stalls", {30'h0, stall_if, stall_mem}, 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    chk("rst_mem_rw_size", {30'h0, mem_rw, mem_size}, 32'h0);
    chk("rst_rdata", if_rdata | dm_rdata, 32'h0);
    @(posedge clk);
    #1;
    if_req  = 1'b0;
    dm_req  = 1'b0;
    reset_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Fetch alone, immediate ready: grant and ack in N+1.
    if_addr = 32'h0000_0010;
    if_req  = 1'b1;
    push_exp(1'b0, 32'h10, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    chk("if_n_mem_en", {31'h0, mem_en}, 32'h0);
    chk("if_n_stall", {31'h0, stall_if}, 32'h1);
    @(negedge clk);
    chk("if_n1_mem_en", {31'h0, mem_en}, 32'h1);
    chk("if_n1_ack", {31'h0, if_ack}, 32'h1);
    chk("if_n1_stall", {31'h0, stall_if}, 32'h0);
    @(posedge clk);
    #1;
    if_req = 1'b0;
    @(negedge clk);
    chk("if_after_mem_en", {31'h0, mem_en}, 32'h0);
    @(posedge clk);
    #1;

    // Simultaneous requests: data first, fetch after one IDLE cycle.
    if_addr = 32'h0000_0100;
    dm_addr = 32'h0000_0040;
    dm_rw   = 1'b0;
    dm_size = 1'b0;
    dm_wdata = 32'h0;
    if_req  = 1'b1;
    dm_req  = 1'b1;
    push_exp(1'b1, 32'h40, 32'h0, 1'b0, 1'b0);
    push_exp(1'b0, 32'h100, 32'h0, 1'b0, 1'b0);
    serve(20, 0);
    chk("if_after_dm_gap", if_ack_cyc - dm_ack_cyc, 32'd2);
    repeat (2) @(posedge clk);
    #1;

    // Data held high with fetch waiting: four data grants, fetch, data resumes.
    if_addr  = 32'h0000_0300;
    dm_addr  = 32'h0000_0200;
    dm_wdata = 32'h0;
    if_req   = 1'b1;
    dm_req   = 1'b1;
    for (int i = 0; i < 4; i++) push_exp(1'b1, 32'h200, 32'h0, 1'b0, 1'b0);
    push_exp(1'b0, 32'h300, 32'h0, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) push_exp(1'b1, 32'h200, 32'h0, 1'b0, 1'b0);
    serve(40, 2);
    chk("burst_drained", exp_q.size(), 32'h0);
    repeat (2) @(posedge clk);
    #1;

    // Byte store with three wait cycles.
    wait_cfg = 3;
    dm_addr  = 32'h0000_0084;
    dm_wdata = 32'h0000_00AB;
    dm_rw    = 1'b1;
    dm_size  = 1'b1;
    dm_req   = 1'b1;
    push_exp(1'b1, 32'h84, 32'hAB, 1'b1, 1'b1);
    @(negedge clk);
    chk("st_n_stall", {31'h0, stall_mem}, 32'h1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("st_mem_en", {31'h0, mem_en}, 32'h1);
      chk("st_rw_size", {30'h0, mem_rw, mem_size}, 32'h3);
      chk("st_ack", {31'h0, dm_ack}, (i == 3) ? 32'h1 : 32'h0);
      chk("st_stall", {31'h0, stall_mem}, (i == 3) ? 32'h0 : 32'h1);
    end
    @(posedge clk);
    #1;
    dm_req = 1'b0;
    dm_rw  = 1'b0;
    dm_size = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Reset during a data wait cycle: strobe drops at once, no ack later.
    wait_cfg = 5;
    dm_addr  = 32'h0000_0400;
    dm_wdata = 32'h0;
    dm_req   = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rm_mem_en_before", {31'h0, mem_en}, 32'h1);
    chk("rm_ack_before", {31'h0, dm_ack}, 32'h0);
    #2;
    reset_n = 1'b0;
    #1;
    chk("rm_mem_en_async", {31'h0, mem_en}, 32'h0);
    chk("rm_stall_gated", {31'h0, stall_mem}, 32'h0);
    dm_req = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    wait_cfg = 0;
    acks_before = total_acks;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("rm_idle_mem_en", {31'h0, mem_en}, 32'h0);
    end
    chk("rm_no_ack", total_acks - acks_before, 32'h0);

    // mem_ready while idle is ignored.
    idle_ready = 1'b1;
    @(posedge clk);
    acks_before = total_acks;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("idle_ready_seen", {31'h0, mem_ready}, 32'h1);
      chk("idle_mem_en", {31'h0, mem_en}, 32'h0);
      chk("idle_acks", {30'h0, if_ack, dm_ack}, 32'h0);
    end
    chk("idle_no_ack", total_acks - acks_before, 32'h0);
    idle_ready = 1'b0;

    @(negedge clk);
    chk("exp_queue_drained", exp_q.size(), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
